// File: rtl/split_target_pkg.sv
// Shared types and constants for the split-capable memory target.
package split_target_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_WDATA,
    S_RWAIT,
    S_SPLIT_WAIT,
    S_SPLIT_REQ,
    S_RESP
  } state_t;

  localparam int   ADDR_BYTES = 2;
  localparam logic RW_WRITE   = 1'b1;
  localparam logic RW_READ    = 1'b0;

endpackage

// File: rtl/target_bram.sv
// Single-port byte RAM: synchronous write, combinational read, no reset.
module target_bram #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/split_target_mem.sv
// Memory-backed bus target with split reads for slow accesses.
// Optional grant timeout in SPLIT_REQ: define SPLIT_TARGET_GRANT_TIMEOUT_EN.
//
// state        | meaning
// S_IDLE       | ready; addr_pend=1 is the ADDR_LO sub-phase (waiting first byte)
// S_ADDR_HI    | waiting for address high byte
// S_WDATA      | waiting for write data byte
// S_RWAIT      | in-place read, latency countdown
// S_SPLIT_WAIT | split read, latency countdown with bus released
// S_SPLIT_REQ  | requesting the bus back, waiting for split_grant
// S_RESP       | one-cycle response (tx_valid or ack), then IDLE
module split_target_mem
  import split_target_pkg::*;
#(
  parameter int ADDR_W          = 12,
  parameter int MEM_DEPTH       = 4096,
  parameter int READ_LATENCY    = 4,
  parameter int SPLIT_THRESHOLD = 2,
  parameter int GRANT_TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       txn_start,
  input  logic       txn_rw,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       split_grant,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       ready,
  output logic       ack,
  output logic       split_ack,
  output logic       split_req,
  output logic       timeout_err
);

  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam bit USE_SPLIT = READ_LATENCY > SPLIT_THRESHOLD;
  // Counter terminates at 1 so tx_valid lands READ_LATENCY cycles after the high byte.
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LATENCY - 1);
  localparam logic [LAT_W-1:0] LAT_TC   = LAT_W'(1);

  state_t                  state;
  logic                    addr_pend;
  logic                    rw;
  logic [7:0]              addr_lo;
  logic [ADDR_W-1:0]       addr;
  logic [LAT_W-1:0]        lat_cnt;
  logic [8*ADDR_BYTES-1:0] addr_full;
  logic [ADDR_W-1:0]       hi_addr;
  logic [ADDR_W-1:0]       ram_addr;
  logic [7:0]              rd_data;
  logic                    wr_en;

  assign addr_full = {rx_data, addr_lo};
  assign hi_addr   = addr_full[ADDR_W-1:0];
  assign ram_addr  = (state == S_ADDR_HI) ? hi_addr : addr;
  assign wr_en     = (state == S_WDATA) && rx_valid;

  if (ADDR_W < 8*ADDR_BYTES) begin : g_addr_trunc
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_full[8*ADDR_BYTES-1:ADDR_W];
  end

  target_bram #(.DEPTH(MEM_DEPTH), .AW(ADDR_W)) u_bram (
    .clk   (clk),
    .we    (wr_en),
    .addr  (ram_addr),
    .wdata (rx_data),
    .rdata (rd_data)
  );

`ifdef SPLIT_TARGET_GRANT_TIMEOUT_EN
  localparam int GT_W = $clog2(GRANT_TIMEOUT + 1);
  logic [GT_W-1:0] gnt_cnt;
`else
  localparam int unused_grant_timeout = GRANT_TIMEOUT;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_pend <= 1'b0;
      rw        <= RW_READ;
      addr_lo   <= '0;
      addr      <= '0;
      lat_cnt   <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      ready     <= 1'b1;
      ack       <= 1'b0;
      split_ack <= 1'b0;
      split_req <= 1'b0;
`ifdef SPLIT_TARGET_GRANT_TIMEOUT_EN
      gnt_cnt     <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      tx_valid  <= 1'b0;
      ack       <= 1'b0;
      split_ack <= 1'b0;
`ifdef SPLIT_TARGET_GRANT_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (!addr_pend) begin
            if (txn_start) begin
              rw    <= txn_rw;
              ready <= 1'b0;
              if (rx_valid) begin
                addr_lo <= rx_data;
                state   <= S_ADDR_HI;
              end else begin
                addr_pend <= 1'b1;
              end
            end
          end else if (rx_valid) begin
            addr_lo   <= rx_data;
            addr_pend <= 1'b0;
            state     <= S_ADDR_HI;
          end
        end
        S_ADDR_HI: begin
          if (rx_valid) begin
            addr <= hi_addr;
            if (rw == RW_WRITE) begin
              state <= S_WDATA;
            end else if (USE_SPLIT) begin
              split_ack <= 1'b1;
              lat_cnt   <= LAT_LOAD;
              state     <= S_SPLIT_WAIT;
            end else if (READ_LATENCY == 1) begin
              tx_valid <= 1'b1;
              tx_data  <= rd_data;
              state    <= S_RESP;
            end else begin
              lat_cnt <= LAT_LOAD;
              state   <= S_RWAIT;
            end
          end
        end
        S_WDATA: begin
          if (rx_valid) begin
            ack   <= 1'b1;
            state <= S_RESP;
          end
        end
        S_RWAIT: begin
          if (lat_cnt <= LAT_TC) begin
            tx_valid <= 1'b1;
            tx_data  <= rd_data;
            state    <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        S_SPLIT_WAIT: begin
          if (lat_cnt <= LAT_TC) begin
            split_req <= 1'b1;
            state     <= S_SPLIT_REQ;
`ifdef SPLIT_TARGET_GRANT_TIMEOUT_EN
            gnt_cnt <= GT_W'(GRANT_TIMEOUT);
`endif
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        S_SPLIT_REQ: begin
          // A grant arriving on the expiry cycle still gets the normal response.
          if (split_grant) begin
            split_req <= 1'b0;
            tx_valid  <= 1'b1;
            tx_data   <= rd_data;
            state     <= S_RESP;
          end
`ifdef SPLIT_TARGET_GRANT_TIMEOUT_EN
          else if (gnt_cnt <= GT_W'(1)) begin
            split_req   <= 1'b0;
            timeout_err <= 1'b1;
            ready       <= 1'b1;
            state       <= S_IDLE;
          end else begin
            gnt_cnt <= gnt_cnt - 1'b1;
          end
`endif
        end
        S_RESP: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_split_target_mem.sv
// Bench for split_target_mem: a split instance (latency 4) and an in-place instance (latency 2).
// Build with SPLIT_TARGET_GRANT_TIMEOUT_EN to also exercise the grant timeout.
module tb_split_target_mem;

  localparam int LAT_S = 4;
  localparam int LAT_F = 2;
  localparam int GTO   = 8;
`ifdef SPLIT_TARGET_GRANT_TIMEOUT_EN
  localparam int HOLD = 5;
`else
  localparam int HOLD = 10;
`endif

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       txn_start   [2];
  logic       txn_rw      [2];
  logic [7:0] rx_data     [2];
  logic       rx_valid    [2];
  logic       split_grant [2];
  logic [7:0] tx_data     [2];
  logic       tx_valid    [2];
  logic       ready       [2];
  logic       ack         [2];
  logic       split_ack   [2];
  logic       split_req   [2];
  logic       timeout_err [2];

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   fast_split_seen = 0;

  split_target_mem #(.READ_LATENCY(LAT_S), .SPLIT_THRESHOLD(2), .GRANT_TIMEOUT(GTO)) u_split (
    .clk(clk), .rst_n(rst_n), .txn_start(txn_start[0]), .txn_rw(txn_rw[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .split_grant(split_grant[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .ready(ready[0]), .ack(ack[0]),
    .split_ack(split_ack[0]), .split_req(split_req[0]), .timeout_err(timeout_err[0])
  );

  split_target_mem #(.READ_LATENCY(LAT_F), .SPLIT_THRESHOLD(2), .GRANT_TIMEOUT(GTO)) u_fast (
    .clk(clk), .rst_n(rst_n), .txn_start(txn_start[1]), .txn_rw(txn_rw[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .split_grant(split_grant[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .ready(ready[1]), .ack(ack[1]),
    .split_ack(split_ack[1]), .split_req(split_req[1]), .timeout_err(timeout_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic mon_pop(input int idx, input logic [7:0] d);
    exp_t e;
    bit   have;
    have = 0;
    if (idx == 0) begin
      if (q0.size() != 0) begin e = q0.pop_front(); have = 1; end
    end else begin
      if (q1.size() != 0) begin e = q1.pop_front(); have = 1; end
    end
    check_val($sformatf("tx_expected%0d", idx), 32'(have), 32'd1);
    if (have) begin
      check_val($sformatf("tx_data%0d", idx), 32'(d), 32'(e.data));
      check_val($sformatf("tx_cycle%0d", idx), 32'(cyc), 32'(e.cyc));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid[0]) mon_pop(0, tx_data[0]);
      if (tx_valid[1]) mon_pop(1, tx_data[1]);
      if (split_ack[1] || split_req[1]) fast_split_seen = 1;
    end
  end

  task automatic push_exp(input int idx, input logic [7:0] d, input int at);
    exp_t e;
    e.data = d;
    e.cyc  = at;
    if (idx == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // All stimulus changes at negedge; DUT samples it on the following posedge.
  task automatic start_txn(input int idx, input logic rw, input logic [7:0] lo, input bit with_byte);
    txn_start[idx] = 1'b1;
    txn_rw[idx]    = rw;
    rx_data[idx]   = lo;
    rx_valid[idx]  = with_byte;
    @(negedge clk);
    txn_start[idx] = 1'b0;
    rx_valid[idx]  = 1'b0;
    if (!with_byte) begin
      check_val("ready_addr_lo_phase", 32'(ready[idx]), 32'd0);
      rx_data[idx]  = lo;
      rx_valid[idx] = 1'b1;
      @(negedge clk);
      rx_valid[idx] = 1'b0;
    end
  endtask

  task automatic send_byte(input int idx, input logic [7:0] b);
    rx_data[idx]  = b;
    rx_valid[idx] = 1'b1;
    @(negedge clk);
    rx_valid[idx] = 1'b0;
  endtask

  task automatic write_txn(input int idx, input logic [7:0] lo, input logic [7:0] hi,
                           input logic [7:0] d, input bit with_byte);
    check_val("ready_before_wr", 32'(ready[idx]), 32'd1);
    start_txn(idx, 1'b1, lo, with_byte);
    check_val("ready_busy", 32'(ready[idx]), 32'd0);
    send_byte(idx, hi);
    check_val("ack_early", 32'(ack[idx]), 32'd0);
    send_byte(idx, d);
    check_val("ack_pulse", 32'(ack[idx]), 32'd1);
    @(negedge clk);
    check_val("ack_clear", 32'(ack[idx]), 32'd0);
    check_val("ready_after_wr", 32'(ready[idx]), 32'd1);
  endtask

  task automatic wait_split_req(output int waited, output bit seen);
    waited = 0;
    while (!split_req[0] && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    seen = split_req[0];
    if (!seen) check_val("split_req_timeout", 32'd0, 32'd1);
  endtask

  task automatic fast_read(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] d);
    start_txn(1, 1'b0, lo, 1'b1);
    send_byte(1, hi);
    push_exp(1, d, cyc + LAT_F - 1);
    repeat (4) @(negedge clk);
    check_val("fast_q_drained", 32'(q1.size()), 32'd0);
    check_val("fast_ready", 32'(ready[1]), 32'd1);
  endtask

  task automatic split_read(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] d,
                            input int gdelay, input bit early_grant);
    int c0, waited, hi_cnt;
    bit seen;
    start_txn(0, 1'b0, lo, 1'b1);
    send_byte(0, hi);
    c0 = cyc;
    check_val("split_ack_pulse", 32'(split_ack[0]), 32'd1);
    check_val("split_req_early", 32'(split_req[0]), 32'd0);
    split_grant[0] = early_grant;
    @(negedge clk);
    split_grant[0] = 1'b0;
    check_val("split_ack_clear", 32'(split_ack[0]), 32'd0);
    wait_split_req(waited, seen);
    if (seen) begin
      check_val("split_req_rise_cyc", 32'(cyc), 32'(c0 + LAT_S - 1));
      hi_cnt = 0;
      for (int k = 0; k < gdelay; k++) begin
        if (split_req[0]) hi_cnt++;
        if (k != gdelay - 1) @(negedge clk);
      end
      check_val("split_req_hold", 32'(hi_cnt), 32'(gdelay));
      split_grant[0] = 1'b1;
      push_exp(0, d, cyc + 1);
      @(negedge clk);
      split_grant[0] = 1'b0;
      check_val("split_req_drop", 32'(split_req[0]), 32'd0);
      repeat (2) @(negedge clk);
      check_val("split_q_drained", 32'(q0.size()), 32'd0);
      check_val("split_ready", 32'(ready[0]), 32'd1);
    end
  endtask

  initial begin
    int  waited;
    bit  seen;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      txn_start[i] = 1'b0; txn_rw[i] = 1'b0; rx_data[i] = 8'h00;
      rx_valid[i] = 1'b0; split_grant[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_val("rst_ready", 32'(ready[i]), 32'd1);
      check_val("rst_tx_valid", 32'(tx_valid[i]), 32'd0);
      check_val("rst_tx_data", 32'(tx_data[i]), 32'd0);
      check_val("rst_ack", 32'(ack[i]), 32'd0);
      check_val("rst_split_ack", 32'(split_ack[i]), 32'd0);
      check_val("rst_split_req", 32'(split_req[i]), 32'd0);
      check_val("rst_timeout_err", 32'(timeout_err[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Stray byte with no txn_start must not start a transaction.
    send_byte(0, 8'h55);
    check_val("stray_rx_ready", 32'(ready[0]), 32'd1);

    write_txn(0, 8'h23, 8'h01, 8'hC5, 1'b1);
    write_txn(1, 8'h23, 8'h01, 8'hC5, 1'b0);

    fast_read(8'h23, 8'h01, 8'hC5);
    check_val("fast_no_split", 32'(fast_split_seen), 32'd0);

    split_read(8'h23, 8'h01, 8'hC5, HOLD, 1'b1);

    // High byte 0xF1 wraps to 0x1 with a 12-bit address.
    write_txn(0, 8'h23, 8'hF1, 8'hA7, 1'b1);
    split_read(8'h23, 8'h01, 8'hA7, 1, 1'b0);
    write_txn(1, 8'hFF, 8'h00, 8'h5A, 1'b1);
    fast_read(8'hFF, 8'h00, 8'h5A);
    fast_read(8'h23, 8'hF1, 8'hC5);

    // Reset while requesting the bus back.
    start_txn(0, 1'b0, 8'h23, 1'b1);
    send_byte(0, 8'h01);
    wait_split_req(waited, seen);
    rst_n = 1'b0;
    #1;
    check_val("midrst_split_req", 32'(split_req[0]), 32'd0);
    check_val("midrst_tx_valid", 32'(tx_valid[0]), 32'd0);
    check_val("midrst_ack", 32'(ack[0]), 32'd0);
    check_val("midrst_ready", 32'(ready[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    split_read(8'h23, 8'h01, 8'hA7, 2, 1'b0);

`ifdef SPLIT_TARGET_GRANT_TIMEOUT_EN
    begin
      int hi_cnt;
      start_txn(0, 1'b0, 8'h23, 1'b1);
      send_byte(0, 8'h01);
      wait_split_req(waited, seen);
      hi_cnt = 0;
      while (split_req[0] && hi_cnt < 30) begin
        hi_cnt++;
        @(negedge clk);
      end
      check_val("to_hold_cycles", 32'(hi_cnt), 32'(GTO));
      check_val("to_err_pulse", 32'(timeout_err[0]), 32'd1);
      check_val("to_ready", 32'(ready[0]), 32'd1);
      split_grant[0] = 1'b1;
      @(negedge clk);
      split_grant[0] = 1'b0;
      check_val("to_err_clear", 32'(timeout_err[0]), 32'd0);
      repeat (3) @(negedge clk);
      check_val("to_late_grant_req", 32'(split_req[0]), 32'd0);
      check_val("to_late_grant_ready", 32'(ready[0]), 32'd1);
    end
`endif

    repeat (5) @(negedge clk);
    check_val("final_q0_empty", 32'(q0.size()), 32'd0);
    check_val("final_q1_empty", 32'(q1.size()), 32'd0);
    check_val("final_fast_no_split", 32'(fast_split_seen), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/split_target_mem.md
Name: split_target_mem

Overview:
- Memory-backed, split-capable bus target; sits directly downstream of split_target_port and consumes its deserialised bytes and split grant.
- Receives a 2-byte address, then a data byte for writes, over the port's parallel byte interface.
- Reads faster than the split threshold are answered in place. Slower reads issue a split, release the bus, and re-request it via the port's arbiter path before returning the byte.

Parameters:
- ADDR_W, 12, memory address width; address bytes above this width are ignored.
- MEM_DEPTH, 4096, number of bytes of storage; must equal 2**ADDR_W.
- READ_LATENCY, 4, cycles from address completion to read data ready; minimum 1.
- SPLIT_THRESHOLD, 2, reads with READ_LATENCY > SPLIT_THRESHOLD use split.
- GRANT_TIMEOUT, 64, cycles to wait for split_grant; used only with the macro.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- txn_start  in  1  one-cycle pulse: this target selected for a new transaction
- txn_rw  in  1  sampled with txn_start; 1=write, 0=read
- rx_data  in  8  byte from port (target_data_in)
- rx_valid  in  1  rx_data valid, one cycle per byte
- split_grant  in  1  bus regranted to this target after split
- tx_data  out  8  read byte to port (target_data_out)
- tx_valid  out  1  one-cycle pulse, tx_data valid
- ready  out  1  high only in IDLE
- ack  out  1  one-cycle write-complete pulse
- split_ack  out  1  one-cycle pulse: transaction is being split
- split_req  out  1  level: request bus back for split response
- timeout_err  out  1  one-cycle pulse on grant timeout; tied 0 without macro

Behaviour:
- Reset: state IDLE, all outputs 0 except ready=1. tx_data is 0. Memory contents are not reset. Reset mid-transaction aborts to IDLE immediately, with no ack or tx_valid.
- States: IDLE, ADDR_HI, WDATA, RWAIT, SPLIT_WAIT, SPLIT_REQ, RESP.
- IDLE:
  - On txn_start, latch txn_rw.
  - If rx_valid is high in the same cycle, rx_data is the address low byte and the FSM goes to ADDR_HI.
  - Otherwise it waits in an internal ADDR_LO sub-phase (treated as part of IDLE with ready=0) for the first rx_valid.
  - rx_valid without a prior txn_start is ignored.
- ADDR_HI:
  - Next rx_valid gives the address high byte; bits above ADDR_W-8 are discarded, so the address wraps modulo MEM_DEPTH.
  - Write goes to WDATA.
  - Read loads the latency counter with READ_LATENCY; goes to RWAIT if READ_LATENCY <= SPLIT_THRESHOLD, else SPLIT_WAIT.
- WDATA:
  - On rx_valid, write rx_data to memory in that cycle.
  - ack pulses the next cycle, then IDLE.
- RWAIT:
  - Counter decrements each cycle; at 0, RESP.
  - tx_valid pulses exactly READ_LATENCY cycles after the cycle that accepted the high address byte, with tx_data = mem[addr]. Then IDLE.
- SPLIT_WAIT:
  - split_ack pulses in the first cycle after the high address byte is accepted.
  - Counter runs as in RWAIT; at 0, SPLIT_REQ.
- SPLIT_REQ:
  - split_req held high.
  - On the first posedge with split_grant=1, go to RESP; split_req is low and tx_valid high in the next cycle.
  - split_grant while not in SPLIT_REQ is ignored.
- All pulses are exactly one cycle. txn_start and rx_valid while not in IDLE or awaiting a byte are ignored. ready=0 outside IDLE.

Optional Feature:
- Macro SPLIT_TARGET_GRANT_TIMEOUT_EN.
- Defined:
  - A counter runs while in SPLIT_REQ.
  - After GRANT_TIMEOUT cycles without grant, drop split_req, pulse timeout_err, and return to IDLE with no tx_valid.
  - A grant in the same cycle as expiry wins (normal response).
- Undefined: SPLIT_REQ waits indefinitely; timeout_err is constant 0.

Decomposition:
- Package split_target_pkg: state enum typedef, ADDR_BYTES=2 constant, RW_WRITE/RW_READ constants.
- Sub-module target_bram: single-port byte RAM, synchronous write, combinational read; depth MEM_DEPTH, width 8.
- FSM and counters live in split_target_mem.

Test Plan:
- Write: txn_start rw=1, bytes 0x23, 0x01, 0xC5 -> mem[0x123]=0xC5, ack pulse 1 cycle after data byte, ready returns high.
- Non-split read, READ_LATENCY=2: read 0x123 -> no split_ack or split_req; tx_valid=1 with tx_data=0xC5 exactly 2 cycles after high address byte.
- Split read, READ_LATENCY=4: read 0x123, withhold split_grant 10 cycles after split_req rises -> split_ack pulse once; split_req high for 10 cycles; grant -> tx_data=0xC5 next cycle, split_req low.
- Address wrap: write 0xA7 to bytes 0x23, 0xF1 -> lands at 0x123; read back 0xA7.
- Reset mid-split: assert rst_n=0 while in SPLIT_REQ -> split_req, tx_valid, ack all 0; ready=1; mem[0x123] retained.
- With SPLIT_TARGET_GRANT_TIMEOUT_EN and GRANT_TIMEOUT=8: no grant -> timeout_err pulse after 8 cycles of split_req, then IDLE; a later grant is ignored.
